// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit (mul_div_unit):
// opcode encodings, FSM state type, default widths and the divide-by-zero
// LO constant. Optional build macro used by the unit: MDU_DIVZERO_FLAG_EN.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_CNT_W = 5;

  // MDUopcode encodings; bit 1 selects divide, bit 0 selects signed.
  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // LO value produced by a divide with a zero divisor.
  localparam logic [MDU_WIDTH-1:0] DIVZ_LO = '1;

endpackage

// File: rtl/mdu_if.sv
// Handshake/operand/result bundle between EX-stage control and the MDU.
// master: control side (drives start/opcode/operands/moves, reads status).
// slave : the MDU itself.
// Signals: start, MDUopcode[1:0], rega, regb, mthi, mtlo, wdata (to MDU);
//          busy, done, hi, lo (from MDU); divzero when MDU_DIVZERO_FLAG_EN.
interface mdu_if;
  import mdu_pkg::*;

  logic                 start;
  logic [1:0]           MDUopcode;
  logic [MDU_WIDTH-1:0] rega;
  logic [MDU_WIDTH-1:0] regb;
  logic                 mthi;
  logic                 mtlo;
  logic [MDU_WIDTH-1:0] wdata;
  logic                 busy;
  logic                 done;
  logic [MDU_WIDTH-1:0] hi;
  logic [MDU_WIDTH-1:0] lo;
`ifdef MDU_DIVZERO_FLAG_EN
  logic                 divzero;

  modport master (
    output start, MDUopcode, rega, regb, mthi, mtlo, wdata,
    input  busy, done, hi, lo, divzero
  );
  modport slave (
    input  start, MDUopcode, rega, regb, mthi, mtlo, wdata,
    output busy, done, hi, lo, divzero
  );
`else
  modport master (
    output start, MDUopcode, rega, regb, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );
  modport slave (
    input  start, MDUopcode, rega, regb, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
`endif

endinterface

// File: rtl/mdu_sign_fix.sv
// Combinational conditional two's-complement.
// wide=1 : negate the full 2W-bit value when neg_lo (signed product).
// wide=0 : negate upper half when neg_hi and lower half when neg_lo
//          independently (remainder/quotient, or operand abs at launch).
// Ports: val (in, 2W), wide, neg_hi, neg_lo (in), res_c (out, 2W, comb).
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [2*W-1:0] val,
  input  logic           wide,
  input  logic           neg_hi,
  input  logic           neg_lo,
  output logic [2*W-1:0] res_c
);

  always_comb begin
    res_c = val;
    if (wide) begin
      if (neg_lo) res_c = -val;
    end else begin
      if (neg_hi) res_c[2*W-1:W] = -val[2*W-1:W];
      if (neg_lo) res_c[W-1:0]   = -val[W-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// MULT/MULTU: shift-add over {acc,mplr}; DIV/DIVU: restoring shift-subtract
// over {rem,quo}; WIDTH iterations then one sign fix-up cycle.
// Ports: CLK, Reset (sync, active-high), bus (mdu_if.slave).
// Build macro MDU_DIVZERO_FLAG_EN: adds bus.divzero and lets a divide by
// zero bypass the iteration phase (IDLE -> FIX).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = MDU_CNT_W
) (
  input  logic CLK,
  input  logic Reset,
  mdu_if.slave bus
);

  localparam int unsigned W2 = 2 * WIDTH;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [W2-1:0]    hl, hl_nxt;
  logic [WIDTH-1:0] opb, opb_nxt;
  logic [WIDTH-1:0] hi_q, hi_nxt;
  logic [WIDTH-1:0] lo_q, lo_nxt;
  logic             is_div, is_div_nxt;
  logic             neg_hi, neg_hi_nxt;
  logic             neg_lo, neg_lo_nxt;
  logic             dz, dz_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
`ifdef MDU_DIVZERO_FLAG_EN
  logic             divzero_q, divzero_nxt;
`endif

  logic             sgn_op;
  logic             launch_dz;
  logic [W2-1:0]    abs_ab_c;
  logic [W2-1:0]    res_c;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_step;
  logic [WIDTH:0]   rem_ext;
  logic [WIDTH+1:0] div_diff;
  logic [W2-1:0]    div_step;

  assign sgn_op    = bus.MDUopcode[0];
  assign launch_dz = bus.MDUopcode[1] & (bus.regb == '0);

  // Operand magnitudes at launch: {|rega|, |regb|} for signed ops, raw otherwise.
  mdu_sign_fix #(.W(WIDTH)) u_abs (
    .val   ({bus.rega, bus.regb}),
    .wide  (1'b0),
    .neg_hi(sgn_op & bus.rega[WIDTH-1]),
    .neg_lo(sgn_op & bus.regb[WIDTH-1]),
    .res_c (abs_ab_c)
  );

  // Result sign fix-up: whole product for multiply, rem/quo halves for divide.
  mdu_sign_fix #(.W(WIDTH)) u_res (
    .val   (hl),
    .wide  (~is_div),
    .neg_hi(neg_hi),
    .neg_lo(neg_lo),
    .res_c (res_c)
  );

  // One shift-add step; the carry out of acc lands in the top bit.
  assign mul_sum  = {1'b0, hl[W2-1:WIDTH]} + (hl[0] ? {1'b0, opb} : '0);
  assign mul_step = {mul_sum, hl[WIDTH-1:1]};

  // One restoring step; rem_ext can reach WIDTH+1 bits, so subtract with a guard bit.
  assign rem_ext  = {hl[W2-1:WIDTH], hl[WIDTH-1]};
  assign div_diff = {1'b0, rem_ext} - {2'b00, opb};
  assign div_step = div_diff[WIDTH+1] ? {rem_ext[WIDTH-1:0], hl[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], hl[WIDTH-2:0], 1'b1};

  // Next-state and datapath next values.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hl_nxt     = hl;
    opb_nxt    = opb;
    hi_nxt     = hi_q;
    lo_nxt     = lo_q;
    is_div_nxt = is_div;
    neg_hi_nxt = neg_hi;
    neg_lo_nxt = neg_lo;
    dz_nxt     = dz;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
    divzero_nxt = 1'b0;
`endif

    // Moves to HI/LO only land while idle; a same-edge launch still takes them.
    if (!busy_q) begin
      if (bus.mthi) hi_nxt = bus.wdata;
      if (bus.mtlo) lo_nxt = bus.wdata;
    end

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          is_div_nxt = bus.MDUopcode[1];
          neg_hi_nxt = sgn_op & bus.rega[WIDTH-1];
          neg_lo_nxt = sgn_op & (bus.rega[WIDTH-1] ^ bus.regb[WIDTH-1]);
          dz_nxt     = launch_dz;
          opb_nxt    = abs_ab_c[WIDTH-1:0];
          hl_nxt     = {WIDTH'(0), abs_ab_c[W2-1:WIDTH]};
          cnt_nxt    = '0;
          busy_nxt   = 1'b1;
          state_nxt  = ST_RUN;
`ifdef MDU_DIVZERO_FLAG_EN
          // Skip iterating: park |rega| where the remainder would end up.
          if (launch_dz) begin
            hl_nxt    = {abs_ab_c[W2-1:WIDTH], WIDTH'(0)};
            state_nxt = ST_FIX;
          end
`endif
        end
      end
      ST_RUN: begin
        hl_nxt  = is_div ? div_step : mul_step;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        hi_nxt    = res_c[W2-1:WIDTH];
        lo_nxt    = dz ? DIVZ_LO : res_c[WIDTH-1:0];
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
`ifdef MDU_DIVZERO_FLAG_EN
        divzero_nxt = dz;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt    <= '0;
      hl     <= '0;
      opb    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      dz     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
      divzero_q <= 1'b0;
`endif
    end else begin
      cnt    <= cnt_nxt;
      hl     <= hl_nxt;
      opb    <= opb_nxt;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
      is_div <= is_div_nxt;
      neg_hi <= neg_hi_nxt;
      neg_lo <= neg_lo_nxt;
      dz     <= dz_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
`ifdef MDU_DIVZERO_FLAG_EN
      divzero_q <= divzero_nxt;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MDU_DIVZERO_FLAG_EN
  assign bus.divzero = divzero_q;
`endif

endmodule
